// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: opcode constants,
// the canonical NOP and the 2-bit branch-history counter encoding.
package if_stage_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [31:0] INSN_NOP   = 32'h0000_0013;

    // Saturating branch-history counter states
    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_cnt_e;

    // Saturating increment/decrement of a history counter
    function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
        bht_cnt_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != BHT_ST) begin
                nxt = bht_cnt_e'(cur + 2'd1);
            end
        end else begin
            if (cur != BHT_SNT) begin
                nxt = bht_cnt_e'(cur - 2'd1);
            end
        end
        return nxt;
    endfunction

    // True when the instruction word is a conditional branch
    function automatic logic is_branch(input logic [31:0] insn);
        return (insn[6:0] == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/if_stage_bht.sv
// Branch history table: array of 2-bit saturating counters with an
// asynchronous read port and a single write (update) port. The read port
// always returns the value held before any update of the same cycle.
module if_stage_bht
    import if_stage_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int NUM_ENT = 2 ** IDX_W;

    bht_cnt_e cnt_q [NUM_ENT];
    bht_cnt_e cnt_d [NUM_ENT];

    // Next-state of the counter array: only the addressed entry moves
    always_comb begin
        cnt_d = cnt_q;
        if (upd_en) begin
            cnt_d[upd_idx] = bht_next(cnt_q[upd_idx], upd_taken);
        end
    end

    // Counter storage; reset forces every entry to weak not-taken
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                cnt_q[i] <= BHT_WNT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asynchronous read of the pre-update counter value
    always_comb begin
        rd_cnt = cnt_q[rd_idx];
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-fetch mux, instruction-memory address,
// IF/ID pipeline register and the branch prediction for the held insn.
// Build option: define IF_BHT_EN to include the branch history table;
// without it the stage predicts static not-taken and ignores updates.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IM_AW     = 8,
    parameter int          BHT_IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_IF,
    input  logic             redirect_EX,
    input  logic [31:0]      pc_redirect_EX,
    input  logic [31:0]      pc_nxt,
    input  logic             bht_upd_en,
    input  logic [31:0]      bht_upd_pc,
    input  logic             bht_upd_taken,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_dout,
    output logic [31:0]      pc_IF,
    output logic [31:0]      pc_4_IF,
    output logic [31:0]      ir_IF,
    output logic             predict
);

    // pc_IF resets one word before RESET_PC so that the NOP sitting in
    // IF/ID makes ID hand back pc_nxt == RESET_PC as the first fetch.
    localparam logic [31:0] RESET_PC_M4 = RESET_PC - 32'd4;

    logic [31:0] fetch_pc;
    logic [31:0] pc_d,    pc_q;
    logic [31:0] pc_4_d,  pc_4_q;
    logic [31:0] ir_d,    ir_q;

    // Fetch address select: an EX redirect overrides ID's next PC
    always_comb begin
        fetch_pc = redirect_EX ? pc_redirect_EX : pc_nxt;
        im_addr  = fetch_pc[IM_AW+1:2];
    end

    // IF/ID next-state: redirect beats stall, stall holds, else advance
    always_comb begin
        pc_d   = pc_q;
        pc_4_d = pc_4_q;
        ir_d   = ir_q;
        if (redirect_EX) begin
            pc_d   = pc_redirect_EX;
            pc_4_d = pc_redirect_EX + 32'd4;
            ir_d   = im_dout;
        end else if (!stall_IF) begin
            pc_d   = pc_nxt;
            pc_4_d = pc_nxt + 32'd4;
            ir_d   = im_dout;
        end
    end

    // IF/ID pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC_M4;
            pc_4_q <= RESET_PC;
            ir_q   <= INSN_NOP;
        end else begin
            pc_q   <= pc_d;
            pc_4_q <= pc_4_d;
            ir_q   <= ir_d;
        end
    end

    assign pc_IF   = pc_q;
    assign pc_4_IF = pc_4_q;
    assign ir_IF   = ir_q;

`ifdef IF_BHT_EN

    logic [1:0] bht_rd_cnt;

    if_stage_bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc_q[BHT_IDX_W+1:2]),
        .rd_cnt    (bht_rd_cnt),
        .upd_en    (bht_upd_en),
        .upd_idx   (bht_upd_pc[BHT_IDX_W+1:2]),
        .upd_taken (bht_upd_taken)
    );

    // Predict taken only for a branch whose counter is in a taken state
    always_comb begin
        predict = is_branch(ir_q) & bht_rd_cnt[1];
    end

    // Address bits outside the fetch/index windows are intentionally unused
    logic unused_ok;
    assign unused_ok = ^{fetch_pc, bht_upd_pc};

`else

    // Static not-taken: no history storage, updates are dropped
    always_comb begin
        predict = 1'b0;
    end

    logic unused_ok;
    assign unused_ok = ^{fetch_pc, bht_upd_en, bht_upd_pc, bht_upd_taken};

`endif

endmodule
